// File: rtl/dmem_io_responder_if.sv
// Data-side RAM bus between the core's MEM stage and the data responder.
interface dmem_io_responder_if;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_rw;
  logic [31:0] ddata_r;

  modport master (output daddr, output ddata_w, output d_rw, input ddata_r);
  modport slave  (input daddr, input ddata_w, input d_rw, output ddata_r);
endinterface

// File: rtl/dmem_io_responder.sv
// Data-bus responder: word-addressed data RAM plus an aliased I/O page holding
// LEDs, synchronised switches and a prescaled compare-match timer.
module dmem_io_responder #(
  parameter int RAM_WORDS = 128,
  parameter int IO_W      = 10
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  dmem_io_responder_if.slave   bus,
  input  logic [IO_W-1:0]      sw_in,
  output logic [IO_W-1:0]      led_out,
  output logic                 timer_irq
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_SW     = 3'd1;
  localparam logic [2:0] OFF_TCOUNT = 3'd2;
  localparam logic [2:0] OFF_TCMP   = 3'd3;
  localparam logic [2:0] OFF_TCTRL  = 3'd4;
  localparam logic [2:0] OFF_TPRE   = 3'd5;

  logic [31:0]     ram_q [RAM_WORDS];
  logic [IO_W-1:0] led_q, led_d;
  logic [IO_W-1:0] sync1_q, sync2_q;
  logic [31:0]     tcount_q, tcount_d;
  logic [31:0]     tcmp_q, tcmp_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic            flag_q, flag_d;
  logic [15:0]     tpre_q, tpre_d;
  logic [15:0]     pcnt_q, pcnt_d;
  logic            irq_q, irq_d;

  logic            is_io_s;
  logic [2:0]      off_s;
  logic [AW-1:0]   ram_idx_s;
  logic            wr_ram_s;
  logic            wr_io_s;
  logic            tick_s;
  logic            match_s;
  logic [31:0]     rdata_s;
  logic            unused_s;

  assign is_io_s   = bus.daddr[9];
  assign off_s     = bus.daddr[4:2];
  assign ram_idx_s = bus.daddr[2 +: AW];
  assign wr_ram_s  = bus.d_rw & ~is_io_s;
  assign wr_io_s   = bus.d_rw & is_io_s;
  assign tick_s    = ctrl_q[0] & (pcnt_q == tpre_q);
  assign match_s   = (tcount_q == tcmp_q);
  assign unused_s  = ^{bus.daddr[1:0], bus.daddr[8:2]};

  assign led_out     = led_q;
  assign timer_irq   = irq_q;
  assign bus.ddata_r = rdata_s;

  // Combinational read mux; reflects pre-edge state so read-during-write returns old data.
  always_comb begin
    rdata_s = 32'd0;
    if (!is_io_s) begin
      rdata_s = ram_q[ram_idx_s];
    end else begin
      case (off_s)
        OFF_LED:    rdata_s = {{(32-IO_W){1'b0}}, led_q};
        OFF_SW:     rdata_s = {{(32-IO_W){1'b0}}, sync2_q};
        OFF_TCOUNT: rdata_s = tcount_q;
        OFF_TCMP:   rdata_s = tcmp_q;
        OFF_TCTRL:  rdata_s = {23'd0, flag_q, 5'd0, ctrl_q};
        OFF_TPRE:   rdata_s = {16'd0, tpre_q};
        default:    rdata_s = 32'd0;
      endcase
    end
  end

  // Next-state for I/O registers and timer; bus writes override the tick update.
  always_comb begin
    led_d  = led_q;
    tcmp_d = tcmp_q;
    ctrl_d = ctrl_q;
    tpre_d = tpre_q;

    if (wr_io_s && (off_s == OFF_TPRE)) begin
      pcnt_d = 16'd0;
    end else if (tick_s) begin
      pcnt_d = 16'd0;
    end else if (ctrl_q[0]) begin
      pcnt_d = pcnt_q + 16'd1;
    end else begin
      pcnt_d = pcnt_q;
    end

    if (wr_io_s && (off_s == OFF_TCOUNT)) begin
      tcount_d = bus.ddata_w;
    end else if (tick_s && match_s && ctrl_q[1]) begin
      tcount_d = 32'd0;
    end else if (tick_s) begin
      tcount_d = tcount_q + 32'd1;
    end else begin
      tcount_d = tcount_q;
    end

    // A match on this edge beats a simultaneous write-1-to-clear.
    if (tick_s && match_s) begin
      flag_d = 1'b1;
    end else if (wr_io_s && (off_s == OFF_TCTRL) && bus.ddata_w[8]) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end

    if (wr_io_s) begin
      case (off_s)
        OFF_LED:   led_d  = bus.ddata_w[IO_W-1:0];
        OFF_TCMP:  tcmp_d = bus.ddata_w;
        OFF_TCTRL: ctrl_d = bus.ddata_w[2:0];
        OFF_TPRE:  tpre_d = bus.ddata_w[15:0];
        default:   led_d  = led_q;
      endcase
    end else begin
      led_d = led_q;
    end

    irq_d = flag_d & ctrl_d[2];
  end

  // Data RAM storage; contents are not reset and writes are blocked while in reset.
  always_ff @(posedge CLK) begin
    if (wr_ram_s && RESET_N) begin
      ram_q[ram_idx_s] <= bus.ddata_w;
    end
  end

  // I/O, synchroniser and timer state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      led_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      tcount_q <= 32'd0;
      tcmp_q   <= 32'hFFFF_FFFF;
      ctrl_q   <= 3'd0;
      flag_q   <= 1'b0;
      tpre_q   <= 16'd0;
      pcnt_q   <= 16'd0;
      irq_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      sync1_q  <= sw_in;
      sync2_q  <= sync1_q;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      ctrl_q   <= ctrl_d;
      flag_q   <= flag_d;
      tpre_q   <= tpre_d;
      pcnt_q   <= pcnt_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_dmem_io_responder.sv
// Directed plus randomized bench for dmem_io_responder, checked against a
// cycle-level behavioural model of the RAM and I/O page.
module tb_dmem_io_responder;
  localparam int RAM_WORDS = 128;
  localparam int IO_W      = 10;

  logic            CLK;
  logic            RESET_N;
  logic [IO_W-1:0] sw_in;
  logic [IO_W-1:0] led_out;
  logic            timer_irq;

  dmem_io_responder_if bus ();

  dmem_io_responder #(.RAM_WORDS(RAM_WORDS), .IO_W(IO_W)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] m_ram [RAM_WORDS];
  bit          m_ram_v [RAM_WORDS];
  logic [9:0]  m_led, m_s1, m_s2;
  logic [31:0] m_tcount, m_tcmp;
  logic [15:0] m_tpre, m_pcnt;
  bit          m_en, m_ar, m_ie, m_flag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_led = 10'd0; m_s1 = 10'd0; m_s2 = 10'd0;
    m_tcount = 32'd0; m_tcmp = 32'hFFFF_FFFF;
    m_tpre = 16'd0; m_pcnt = 16'd0;
    m_en = 0; m_ar = 0; m_ie = 0; m_flag = 0;
  endtask

  task automatic m_read(input logic [9:0] a, output logic [31:0] v, output bit kn);
    int unsigned ai;
    ai = a;
    v  = 32'd0;
    kn = 1;
    if (ai < 512) begin
      v  = m_ram[(ai / 4) % RAM_WORDS];
      kn = m_ram_v[(ai / 4) % RAM_WORDS];
    end else begin
      case ((ai / 4) % 8)
        0: v = {22'd0, m_led};
        1: v = {22'd0, m_s2};
        2: v = m_tcount;
        3: v = m_tcmp;
        4: v = {23'd0, m_flag, 5'd0, m_ie, m_ar, m_en};
        5: v = {16'd0, m_tpre};
        default: v = 32'd0;
      endcase
    end
  endtask

  // One rising edge of the responder, derived from the register-map rules.
  task automatic m_edge(input logic [9:0] a, input logic [31:0] w, input logic rw);
    int unsigned ai;
    bit tick, hit, nf;
    logic [31:0] nc;
    logic [15:0] np;
    ai = a; tick = 0; hit = 0;
    np = m_pcnt; nc = m_tcount; nf = m_flag;
    if (m_en) begin
      if (m_pcnt == m_tpre) begin tick = 1; np = 16'd0; end
      else np = m_pcnt + 16'd1;
    end
    if (tick) begin
      hit = (m_tcount == m_tcmp);
      nc  = (hit && m_ar) ? 32'd0 : m_tcount + 32'd1;
      if (hit) nf = 1;
    end
    if (rw) begin
      if (ai < 512) begin
        m_ram[(ai / 4) % RAM_WORDS]   = w;
        m_ram_v[(ai / 4) % RAM_WORDS] = 1;
      end else begin
        case ((ai / 4) % 8)
          0: m_led = w[9:0];
          2: nc = w;
          3: m_tcmp = w;
          4: begin
            m_en = w[0]; m_ar = w[1]; m_ie = w[2];
            if (w[8] && !hit) nf = 0;
          end
          5: begin m_tpre = w[15:0]; np = 16'd0; end
          default: ;
        endcase
      end
    end
    m_s2 = m_s1; m_s1 = sw_in;
    m_tcount = nc; m_pcnt = np; m_flag = nf;
  endtask

  // Drive one bus cycle, check pre-edge outputs against the model, then advance.
  task automatic step(input logic [9:0] a, input logic [31:0] w, input logic rw, input string tag);
    logic [31:0] ev;
    bit kn;
    bus.daddr = a; bus.ddata_w = w; bus.d_rw = rw;
    #4;
    m_read(a, ev, kn);
    if (kn) check({tag, "/rd"}, bus.ddata_r, ev);
    check({tag, "/led"}, {22'd0, led_out}, {22'd0, m_led});
    check({tag, "/irq"}, {31'd0, timer_irq}, {31'd0, (m_flag & m_ie)});
    @(posedge CLK);
    m_edge(a, w, rw);
    #1;
  endtask

  task automatic peek(input logic [9:0] a, input logic [31:0] exp, input string tag);
    bus.d_rw = 1'b0; bus.daddr = a;
    #1;
    check(tag, bus.ddata_r, exp);
  endtask

  initial begin
    logic [9:0]  a;
    logic [31:0] w;
    logic        rw;
    int          k;

    RESET_N = 1'b0; sw_in = '0;
    bus.daddr = 10'h208; bus.ddata_w = 32'd0; bus.d_rw = 1'b0;
    m_reset();
    #8;
    check("rst/tcount", bus.ddata_r, 32'd0);
    bus.daddr = 10'h20C; #1;
    check("rst/tcmp", bus.ddata_r, 32'hFFFF_FFFF);
    bus.daddr = 10'h210; #1;
    check("rst/tctrl", bus.ddata_r, 32'd0);
    check("rst/led", {22'd0, led_out}, 32'd0);
    check("rst/irq", {31'd0, timer_irq}, 32'd0);
    RESET_N = 1'b1;
    @(posedge CLK);
    m_edge(bus.daddr, 32'd0, 1'b0);
    #1;

    // RAM write/read and read-during-write
    step(10'h004, 32'hDEAD_BEEF, 1'b1, "ram_w0");
    step(10'h1FC, 32'h1234_5678, 1'b1, "ram_w1");
    peek(10'h004, 32'hDEAD_BEEF, "ram_rd0");
    peek(10'h1FC, 32'h1234_5678, "ram_rd1");
    step(10'h004, 32'hCAFE_F00D, 1'b1, "rdw");
    peek(10'h004, 32'hCAFE_F00D, "rdw_after");

    // LEDs and switch synchroniser
    step(10'h200, 32'h0000_03FF, 1'b1, "led_w");
    check("led_val", {22'd0, led_out}, 32'h0000_03FF);
    sw_in = 10'h155;
    step(10'h204, 32'd0, 1'b0, "sw0");
    step(10'h204, 32'd0, 1'b0, "sw1");
    peek(10'h204, 32'h0000_0155, "sw_sync");
    step(10'h204, 32'h0000_0000, 1'b1, "sw_wr");
    peek(10'h204, 32'h0000_0155, "sw_ro");

    // Auto-reload timer with prescale 1, compare 3, irq enabled
    step(10'h214, 32'd1, 1'b1, "tpre");
    step(10'h20C, 32'd3, 1'b1, "tcmp");
    step(10'h210, 32'h7, 1'b1, "tctrl");
    for (int i = 0; i < 8; i++) step(10'h208, 32'd0, 1'b0, "ar_cnt");
    check("ar_irq", {31'd0, timer_irq}, 32'd1);
    peek(10'h208, 32'd0, "ar_reload");
    step(10'h210, 32'h107, 1'b1, "w1c");
    check("w1c_irq", {31'd0, timer_irq}, 32'd0);

    // Free-running wrap without a match, then compare at zero
    step(10'h210, 32'h0, 1'b1, "dis");
    step(10'h208, 32'hFFFF_FFFE, 1'b1, "wrap_ld");
    step(10'h20C, 32'd5, 1'b1, "wrap_cmp");
    step(10'h214, 32'd0, 1'b1, "wrap_pre");
    step(10'h210, 32'h1, 1'b1, "wrap_en");
    for (int i = 0; i < 3; i++) step(10'h208, 32'd0, 1'b0, "wrap");
    peek(10'h210, 32'h0000_0001, "wrap_noflag");
    step(10'h210, 32'h0, 1'b1, "dis2");
    step(10'h208, 32'hFFFF_FFFE, 1'b1, "c0_ld");
    step(10'h20C, 32'd0, 1'b1, "c0_cmp");
    step(10'h210, 32'h1, 1'b1, "c0_en");
    step(10'h208, 32'd0, 1'b0, "c0_a");
    step(10'h208, 32'd0, 1'b0, "c0_b");
    peek(10'h210, 32'h0000_0001, "c0_pre");
    step(10'h208, 32'd0, 1'b0, "c0_c");
    peek(10'h210, 32'h0000_0101, "c0_flag");
    peek(10'h208, 32'd1, "c0_cnt");

    // Collisions: match beats W1C, TCOUNT write beats tick
    step(10'h210, 32'h0, 1'b1, "dis3");
    step(10'h208, 32'd2, 1'b1, "co_ld");
    step(10'h20C, 32'd2, 1'b1, "co_cmp");
    step(10'h210, 32'h100, 1'b1, "co_clr");
    peek(10'h210, 32'h0000_0000, "co_cleared");
    step(10'h210, 32'h1, 1'b1, "co_en");
    step(10'h210, 32'h101, 1'b1, "co_w1c");
    peek(10'h210, 32'h0000_0101, "co_flag_wins");
    step(10'h208, 32'h0000_1234, 1'b1, "co_tcwr");
    peek(10'h208, 32'h0000_1234, "co_tc_wins");

    // Asynchronous reset in the middle of counting
    step(10'h210, 32'h5, 1'b1, "irq_on");
    step(10'h200, 32'h2AA, 1'b1, "led2");
    check("pre_rst_irq", {31'd0, timer_irq}, 32'd1);
    bus.d_rw = 1'b0; bus.daddr = 10'h208;
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst/tcount", bus.ddata_r, 32'd0);
    check("arst/led", {22'd0, led_out}, 32'd0);
    check("arst/irq", {31'd0, timer_irq}, 32'd0);
    m_reset();
    RESET_N = 1'b1;

    // Randomized traffic over RAM and the aliased I/O page
    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(0, 9);
      rw = 1'($urandom_range(0, 1));
      if (k < 4) a = {1'b0, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3))};
      else       a = {1'b1, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      w = $urandom;
      if (a[9]) begin
        case (a[4:2])
          3'd2:    w = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          3'd3:    w = 32'($urandom_range(0, 12));
          3'd5:    w = {w[31:16], 16'($urandom_range(0, 3))};
          default: w = w;
        endcase
      end
      if ($urandom_range(0, 15) == 0) sw_in = 10'($urandom);
      step(a, w, rw, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dmem_io_responder.md
Name: dmem_io_responder

Overview:
- Data-side responder for the pipelined core's RAM bus (daddr / ddata_w / d_rw / ddata_r).
- Decodes every bus access into one of two regions: a word-addressed data RAM, or a small memory-mapped I/O page.
- The I/O page holds an LED output register, a synchronised switch input, and a prescaled 32-bit timer with compare match and interrupt.
- Reads are combinational, so the core can capture ddata_r into its MEM/WB bank at the end of the same cycle; writes commit on the clock edge.

Parameters:
- RAM_WORDS, 128: depth of the data RAM in 32-bit words. Must be ≤128 and a power of two.
- IO_W, 10: width of the LED and switch registers.

Ports:
- CLK, input, 1: system clock, rising edge.
- RESET_N, input, 1: asynchronous active-low reset.
- daddr, input, 10: byte address from the core's MEM stage. Bits [1:0] are ignored.
- ddata_w, input, 32: write data from the core.
- d_rw, input, 1: write enable, 1 = write this cycle.
- ddata_r, output, 32: read data, combinational from daddr.
- sw_in, input, IO_W: asynchronous board switches.
- led_out, output, IO_W: LED register value.
- timer_irq, output, 1: level interrupt, equal to match flag AND irq enable.

Behaviour:
- Address decode
  - word index = daddr[9:2].
  - daddr[9]=0 selects RAM, entry daddr[8:2] modulo RAM_WORDS.
  - daddr[9]=1 selects I/O, register offset daddr[4:2].
  - daddr[8:5] is don't-care in the I/O page, so the page aliases.
- I/O map
  - 0 LED: RW, IO_W bits, zero-extended on read.
  - 1 SW: RO, the 2-flop synchronised sw_in, zero-extended. Writes ignored.
  - 2 TCOUNT: RW, 32-bit. A write loads the counter.
  - 3 TCMP: RW, 32-bit compare value.
  - 4 TCTRL: bit0 enable, bit1 auto-reload, bit2 irq enable (RW); bit8 match flag, read-1 and write-1-to-clear. Other bits read 0.
  - 5 TPRE: RW, 16-bit prescale value, zero-extended.
  - 6, 7: read 0, writes ignored.
- Reads
  - Purely combinational, no side effects; the core drives daddr for non-load instructions too.
  - ddata_r reflects state before the current edge. Read of the same address during a write cycle returns the old value.
- Writes
  - Committed at the rising CLK edge when d_rw=1.
  - RAM is written as a full word; there are no byte enables.
- Reset values
  - led_out=0, timer_irq=0, TCOUNT=0, TCMP=0xFFFFFFFF, TCTRL=0, TPRE=0, prescale counter=0, synchroniser flops=0.
  - RAM contents are not reset (initialisation file or don't-care).
  - Reset asserted mid-operation clears all registers immediately; a write in that cycle is lost.
- Prescaler
  - Runs only when enable=1.
  - pcnt counts 0..TPRE. When pcnt==TPRE, it returns to 0 and a tick is issued that cycle.
  - TPRE=0 gives a tick every cycle. Clearing enable holds pcnt and TCOUNT.
- Tick
  - If TCOUNT==TCMP: flag is set. TCOUNT becomes 0 if auto-reload=1, otherwise TCOUNT+1.
  - Otherwise TCOUNT becomes TCOUNT+1, wrapping 0xFFFFFFFF→0 with no flag.
- Simultaneous events
  - A write to TCOUNT overrides the tick update in the same cycle.
  - Flag set by a match wins over a W1C in the same cycle.
  - A write to TPRE resets pcnt to 0.
  - A write to TCTRL with bit8=0 leaves the flag untouched.
- timer_irq is registered-state derived: it rises the cycle after the match edge and falls the cycle after a W1C edge.

Test Plan:
- RAM write then read: write 0xDEADBEEF to daddr=0x004 and 0x12345678 to 0x1FC, then read both → each returns its value. With RAM_WORDS=128, 0x004 and 0x1FC map to distinct words.
- Read-during-write: 0x004 holds 0xDEADBEEF; write 0xCAFEF00D to 0x004 with daddr held → ddata_r=0xDEADBEEF in the write cycle and 0xCAFEF00D in the next cycle.
- LED/SW: write 0x3FF to 0x200 → led_out=0x3FF on the next cycle. Set sw_in=0x155 → a read of 0x204 returns 0 for 2 edges, then 0x00000155.
- Timer auto-reload: TPRE=1, TCMP=3, TCTRL=0x7 → TCOUNT advances every 2 cycles 0,1,2,3,0. The flag and timer_irq assert after the 3→0 tick. Writing 0x107 to TCTRL clears the irq on the next cycle.
- Free-run wrap: TCOUNT written to 0xFFFFFFFE, TCMP=5, TPRE=0, TCTRL=0x1 → TCOUNT reads 0xFFFFFFFF then 0, flag stays 0. With TCMP=0 instead, the flag sets at the 0→1 tick.
- Collision and reset: a W1C coinciding with a match tick → flag remains 1. A write to TCOUNT on a tick cycle → the written value wins. Asserting RESET_N=0 mid-count → TCOUNT=0, led_out=0 and timer_irq=0 immediately (asynchronously).
